// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
// MMIO register offsets and address region tags.
package cpu_pkg;

    localparam logic [4:0] MMIO_TX     = 5'h00;
    localparam logic [4:0] MMIO_STATUS = 5'h04;
    localparam logic [4:0] MMIO_CYC_LO = 5'h08;
    localparam logic [4:0] MMIO_CYC_HI = 5'h0C;
    localparam logic [4:0] MMIO_HALT   = 5'h10;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data bus plus console byte stream.
// The master drives addr/wdata/strobes and accepts console bytes.
interface data_mem_responder_if;

    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        re;
    logic        we;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output addr, wdata, re, we, tx_ready,
        input  rdata, tx_valid, tx_data
    );

    modport slave (
        input  addr, wdata, re, we, tx_ready,
        output rdata, tx_valid, tx_data
    );

endinterface

// File: rtl/data_mem_responder_fifo.sv
// Synchronous FIFO with occupancy count.
// A push to a full FIFO only lands when a pop frees a slot the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    // Accept/advance decisions and next pointer/count values
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_q + AW'(1);
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset; a push during reset is discarded
    always_ff @(posedge clk_i) begin
        if (do_push && rst_ni) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus MMIO console,
// cycle counter and halt register behind one decode.
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter int          TX_DEPTH  = 8
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] cpu_data_addr_i,
    output logic [31:0] cpu_data_rdata_o,
    input  logic [31:0] cpu_data_wdata_i,
    input  logic        cpu_data_re_i,
    input  logic        cpu_data_we_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        halt_o,
    output logic [31:0] halt_code_o,
    output logic        bus_err_o
);

    localparam int          IW     = $clog2(RAM_WORDS);
    localparam int          CW     = $clog2(TX_DEPTH) + 1;
    localparam logic [29:0] RAM_W  = RAM_BASE[31:2];
    localparam logic [29:0] MMIO_W = MMIO_BASE[31:2];

    logic [31:0] ram_q [RAM_WORDS];
    logic [29:0] ram_woff;
    logic [29:0] mmio_woff;
    logic [4:0]  mmio_off;
    region_t     region;
    logic        legal, bad, rd, wr;
    logic        ram_we, tx_push, stat_wr, halt_wr, lo_rd;

    logic [63:0] cyc_q, cyc_d;
    logic [31:0] hi_q, hi_d;
    logic        ovf_q, ovf_d;
    logic        halt_q, halt_d;
    logic [31:0] code_q, code_d;
    logic        err_q, err_d;

    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;

    // Address decode and access legality
    always_comb begin
        ram_woff  = cpu_data_addr_i[31:2] - RAM_W;
        mmio_woff = cpu_data_addr_i[31:2] - MMIO_W;
        mmio_off  = {mmio_woff[2:0], 2'b00};
        region    = REG_NONE;
        if (ram_woff < 30'(RAM_WORDS)) region = REG_RAM;
        else if (mmio_woff <= 30'd4)   region = REG_MMIO;
        legal = (cpu_data_re_i ^ cpu_data_we_i)
             && (cpu_data_addr_i[1:0] == 2'b00)
             && (region != REG_NONE);
        bad     = (cpu_data_re_i | cpu_data_we_i) && !legal;
        rd      = legal && cpu_data_re_i;
        wr      = legal && cpu_data_we_i;
        ram_we  = wr && (region == REG_RAM) && reset_ni;
        tx_push = wr && (region == REG_MMIO) && (mmio_off == MMIO_TX);
        stat_wr = wr && (region == REG_MMIO) && (mmio_off == MMIO_STATUS);
        halt_wr = wr && (region == REG_MMIO) && (mmio_off == MMIO_HALT);
        lo_rd   = rd && (region == REG_MMIO) && (mmio_off == MMIO_CYC_LO);
    end

    // Combinational read mux; zero unless a legal read is present
    always_comb begin
        cpu_data_rdata_o = '0;
        if (rd) begin
            unique case (region)
                REG_RAM:  cpu_data_rdata_o = ram_q[ram_woff[IW-1:0]];
                REG_MMIO: begin
                    unique case (mmio_off)
                        MMIO_STATUS: cpu_data_rdata_o =
                            {16'b0, 8'(fifo_cnt), 5'b0,
                             ovf_q, fifo_full, fifo_empty};
                        MMIO_CYC_LO: cpu_data_rdata_o = cyc_q[31:0];
                        MMIO_CYC_HI: cpu_data_rdata_o = hi_q;
                        default:     cpu_data_rdata_o = '0;
                    endcase
                end
                default:  cpu_data_rdata_o = '0;
            endcase
        end
    end

    // Next-state for counter, snapshot, overflow, halt and error flags
    always_comb begin
        cyc_d  = cyc_q + 64'd1;
        hi_d   = hi_q;
        ovf_d  = ovf_q;
        halt_d = halt_q;
        code_d = code_q;
        err_d  = err_q | bad;
        if (lo_rd) hi_d = cyc_q[63:32];
        if (tx_push && fifo_full && !tx_ready_i) ovf_d = 1'b1;
        if (stat_wr) ovf_d = 1'b0;
        if (halt_wr && !halt_q) begin
            halt_d = 1'b1;
            code_d = cpu_data_wdata_i;
        end
    end

    // Control and status registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cyc_q  <= '0;
            hi_q   <= '0;
            ovf_q  <= 1'b0;
            halt_q <= 1'b0;
            code_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            hi_q   <= hi_d;
            ovf_q  <= ovf_d;
            halt_q <= halt_d;
            code_q <= code_d;
            err_q  <= err_d;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk_i) begin
        if (ram_we) ram_q[ram_woff[IW-1:0]] <= cpu_data_wdata_i;
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (reset_ni),
        .push_i  (tx_push),
        .data_i  (cpu_data_wdata_i[7:0]),
        .pop_i   (tx_ready_i),
        .data_o  (tx_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign tx_valid_o  = !fifo_empty;
    assign halt_o      = halt_q;
    assign halt_code_o = code_q;
    assign bus_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder.
// Stimulus queues expectations; a negedge monitor checks them.
module tb_data_mem_responder;

    localparam logic [31:0] MB     = 32'h8000_0000;
    localparam logic [31:0] A_TX   = MB + 32'h00;
    localparam logic [31:0] A_STAT = MB + 32'h04;
    localparam logic [31:0] A_LO   = MB + 32'h08;
    localparam logic [31:0] A_HI   = MB + 32'h0C;
    localparam logic [31:0] A_HALT = MB + 32'h10;

    localparam int S_RD   = 0;
    localparam int S_TXV  = 1;
    localparam int S_TXD  = 2;
    localparam int S_HALT = 3;
    localparam int S_CODE = 4;
    localparam int S_ERR  = 5;

    typedef struct {
        int          tag;
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic clk = 1'b0;
    logic reset_ni;
    logic halt;
    logic [31:0] halt_code;
    logic bus_err;

    chk_t       cq[$];
    logic [7:0] txq[$];
    int n_chk  = 0;
    int n_pass = 0;
    int tcyc   = 0;

    data_mem_responder_if bus();

    data_mem_responder #(
        .RAM_WORDS (1024),
        .RAM_BASE  (32'h0000_0000),
        .MMIO_BASE (32'h8000_0000),
        .TX_DEPTH  (8)
    ) dut (
        .clk_i            (clk),
        .reset_ni         (reset_ni),
        .cpu_data_addr_i  (bus.addr),
        .cpu_data_rdata_o (bus.rdata),
        .cpu_data_wdata_i (bus.wdata),
        .cpu_data_re_i    (bus.re),
        .cpu_data_we_i    (bus.we),
        .tx_valid_o       (bus.tx_valid),
        .tx_data_o        (bus.tx_data),
        .tx_ready_i       (bus.tx_ready),
        .halt_o           (halt),
        .halt_code_o      (halt_code),
        .bus_err_o        (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcyc <= tcyc + 1;

    function automatic logic [31:0] sample(input int sel);
        case (sel)
            S_RD:    return bus.rdata;
            S_TXV:   return {31'b0, bus.tx_valid};
            S_TXD:   return {24'b0, bus.tx_data};
            S_HALT:  return {31'b0, halt};
            S_CODE:  return halt_code;
            default: return {31'b0, bus_err};
        endcase
    endfunction

    // Monitor: checks queued expectations and consumed console bytes
    always @(negedge clk) begin
        logic [31:0] act;
        logic [7:0]  eb;
        while (cq.size() > 0 && cq[0].tag <= tcyc) begin
            chk_t e;
            e = cq.pop_front();
            n_chk++;
            if (e.tag < tcyc) begin
                $display("FAIL %s: expectation not sampled in its cycle",
                         e.name);
            end else begin
                act = sample(e.sel);
                if (act === e.exp) n_pass++;
                else $display("FAIL %s: got %h want %h",
                              e.name, act, e.exp);
            end
        end
        if (bus.tx_valid && bus.tx_ready) begin
            n_chk++;
            if (txq.size() == 0) begin
                $display("FAIL tx_pop: got %h want no byte", bus.tx_data);
            end else begin
                eb = txq.pop_front();
                if (bus.tx_data === eb) n_pass++;
                else $display("FAIL tx_pop: got %h want %h",
                              bus.tx_data, eb);
            end
        end
    end

    task automatic op(input logic [31:0] a, input logic [31:0] wd,
                      input logic r, input logic w, input logic rdy);
        @(posedge clk);
        #1;
        bus.addr     = a;
        bus.wdata    = wd;
        bus.re       = r;
        bus.we       = w;
        bus.tx_ready = rdy;
    endtask

    task automatic expect_v(input int sel, input logic [31:0] v,
                            input string n);
        chk_t e;
        e.tag  = tcyc;
        e.sel  = sel;
        e.exp  = v;
        e.name = n;
        cq.push_back(e);
    endtask

    task automatic expect_reset(input string n);
        expect_v(S_RD,   32'h0, {n, "_rdata"});
        expect_v(S_TXV,  32'h0, {n, "_txv"});
        expect_v(S_TXD,  32'h0, {n, "_txd"});
        expect_v(S_HALT, 32'h0, {n, "_halt"});
        expect_v(S_CODE, 32'h0, {n, "_code"});
        expect_v(S_ERR,  32'h0, {n, "_err"});
    endtask

    initial begin
        reset_ni     = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.re       = 1'b0;
        bus.we       = 1'b0;
        bus.tx_ready = 1'b0;

        op(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        expect_reset("rst");
        @(posedge clk);
        #1 reset_ni = 1'b1;

        // RAM write then read next cycle; idle read returns zero
        op(32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        op(32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'hDEAD_BEEF, "ram_rd");
        op(32'h40, 32'h0, 1'b0, 1'b0, 1'b0);
        expect_v(S_RD, 32'h0, "ram_idle");
        expect_v(S_ERR, 32'h0, "err_clean");

        // Two console bytes, then drain in order
        op(A_TX, 32'h41, 1'b0, 1'b1, 1'b0);
        txq.push_back(8'h41);
        op(A_TX, 32'h42, 1'b0, 1'b1, 1'b0);
        txq.push_back(8'h42);
        op(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'h0000_0200, "stat_cnt2");
        expect_v(S_TXV, 32'h1, "txv_pending");
        op(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        op(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        op(A_STAT, 32'h0, 1'b1, 1'b0, 1'b1);
        expect_v(S_RD, 32'h0000_0001, "stat_empty");
        expect_v(S_TXV, 32'h0, "txv_drained");

        // Overfill: ninth byte dropped and ovf raised
        for (int i = 0; i < 9; i++) begin
            op(A_TX, 32'h50 + i, 1'b0, 1'b1, 1'b0);
            if (i < 8) txq.push_back(8'(8'h50 + i));
        end
        op(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'h0000_0806, "stat_ovf");
        op(A_STAT, 32'h1234, 1'b0, 1'b1, 1'b0);
        op(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'h0000_0802, "stat_ovf_clr");
        op(A_TX, 32'h59, 1'b0, 1'b1, 1'b1);
        txq.push_back(8'h59);
        op(A_STAT, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'h0000_0802, "stat_pushpop_full");

        // Counter LO/HI snapshot across the 32-bit carry
        op(A_LO, 32'h0, 1'b1, 1'b0, 1'b0);
        force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
        expect_v(S_RD, 32'hFFFF_FFFF, "cyc_lo_force");
        @(negedge clk);
        #1 release dut.cyc_q;
        op(A_HI, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'h0, "cyc_hi_snap0");
        op(A_LO, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'h0000_0001, "cyc_lo_wrapped");
        op(A_HI, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'h1, "cyc_hi_snap1");

        // Illegal accesses
        op(32'h41, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'h0, "misalign_rd");
        op(32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_ERR, 32'h1, "err_set");
        op(32'h9000_0000, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'h0, "unmapped_rd");
        op(32'h40, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        expect_v(S_RD, 32'h0, "rewe_rd");
        op(32'h42, 32'h1111_1111, 1'b0, 1'b1, 1'b0);
        op(MB + 32'h14, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'h0, "mmio_hole_rd");
        op(32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'hDEAD_BEEF, "ram_unchanged");

        // Halt capture, later halt ignored
        op(A_HALT, 32'h2A, 1'b0, 1'b1, 1'b0);
        op(A_HALT, 32'h7, 1'b0, 1'b1, 1'b0);
        expect_v(S_HALT, 32'h1, "halt_set");
        expect_v(S_CODE, 32'h2A, "halt_code");
        op(A_HALT, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_v(S_RD, 32'h0, "halt_rd");
        expect_v(S_CODE, 32'h2A, "halt_code_kept");

        // Reset in the middle of a drain
        op(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        op(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        op(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        reset_ni = 1'b0;
        txq.delete();
        expect_reset("midrst");
        @(posedge clk);
        #1 reset_ni = 1'b1;
        op(A_STAT, 32'h0, 1'b1, 1'b0, 1'b1);
        expect_v(S_RD, 32'h0000_0001, "post_rst_stat");
        expect_v(S_TXV, 32'h0, "post_rst_txv");
        op(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        if (cq.size() > 0) begin
            n_chk++;
            $display("FAIL scoreboard: got %0d unchecked want 0", cq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
